// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: MUL_CYCLES-deep multiply or 32-step restoring divide, then sign/accumulate fixup.
// Latency accept->DONE: MUL_CYCLES+2 (mul) / 34 (div); stalls the pipe until release, holds DONE under i_pipe_stall.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_srca,
    input  logic [31:0] i_srcb,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic        i_flush,
    input  logic        i_pipe_stall,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_hilo_we,
    output logic [31:0] o_gpr_result,
    output logic        o_gpr_we
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quo;

    logic        w_valid_op;
    logic        w_signed_op;
    logic        w_div_op_in;
    logic        w_accept;
    logic        w_release;
    logic        w_r_is_div;
    logic        w_r_is_gpr;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [31:0] w_a_raw;

    assign w_valid_op  = (i_op <= 4'd8);
    assign w_signed_op = ~i_op[0];
    assign w_div_op_in = (i_op[3:1] == 3'b001);
    assign w_accept    = (r_state == S_IDLE) & i_start & w_valid_op & ~i_flush;
    assign w_release   = (r_state == S_DONE) & ~i_pipe_stall & ~i_flush;
    assign w_r_is_div  = (r_op[3:1] == 3'b001);
    assign w_r_is_gpr  = (r_op == 4'd8);

    assign o_stall   = w_accept
                     | (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX)
                     | ((r_state == S_DONE) & i_pipe_stall);
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_hilo_we = w_release & ~w_r_is_gpr;
    assign o_gpr_we  = w_release & w_r_is_gpr;

    // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    assign w_prod  = (r_sa ^ r_sb) ? (64'd0 - r_prod) : r_prod;
    assign w_div_q = (r_sa ^ r_sb) ? (32'd0 - r_quo) : r_quo;
    assign w_div_r = r_sa ? (32'd0 - r_rem) : r_rem;
    assign w_a_raw = r_sa ? (32'd0 - r_a) : r_a;

    always_comb begin
        w_mul_res = w_prod;
        case (r_op)
            4'd4, 4'd5: w_mul_res = {i_hi, i_lo} + w_prod;
            4'd6, 4'd7: w_mul_res = {i_hi, i_lo} - w_prod;
            default:    w_mul_res = w_prod;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_op         <= 4'd0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_cnt        <= 6'd0;
            r_prod       <= 64'd0;
            r_rem        <= 32'd0;
            r_quo        <= 32'd0;
            o_hi         <= 32'd0;
            o_lo         <= 32'd0;
            o_gpr_result <= 32'd0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= i_op;
                        r_sa  <= w_signed_op & i_srca[31];
                        r_sb  <= w_signed_op & i_srcb[31];
                        r_a   <= (w_signed_op & i_srca[31]) ? (32'd0 - i_srca) : i_srca;
                        r_b   <= (w_signed_op & i_srcb[31]) ? (32'd0 - i_srcb) : i_srcb;
                        r_quo <= (w_signed_op & i_srca[31]) ? (32'd0 - i_srca) : i_srca;
                        r_rem <= 32'd0;
                        r_cnt <= 6'd0;
                        r_state <= w_div_op_in ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod <= {32'd0, r_a} * {32'd0, r_b};
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'(MUL_CYCLES - 1))
                        r_state <= S_FIX;
                end
                S_DIV: begin
                    if (!w_diff[32]) begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    // Zero divisor bypasses the iterated result: all-ones quotient, dividend as remainder.
                    if (w_r_is_gpr) begin
                        o_gpr_result <= w_prod[31:0];
                    end else if (w_r_is_div) begin
                        if (r_b == 32'd0) begin
                            o_hi <= w_a_raw;
                            o_lo <= 32'hFFFF_FFFF;
                        end else begin
                            o_hi <= w_div_r;
                            o_lo <= w_div_q;
                        end
                    end else begin
                        o_hi <= w_mul_res[63:32];
                        o_lo <= w_mul_res[31:0];
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!i_pipe_stall)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] srca = 32'd0;
    logic [31:0] srcb = 32'd0;
    logic [31:0] hi_i = 32'd0;
    logic [31:0] lo_i = 32'd0;
    logic        flush = 1'b0;
    logic        pipe_stall = 1'b0;
    logic        stall, busy, done, hilo_we, gpr_we;
    logic [31:0] hi_o, lo_o, gpr_result;

    int n_chk = 0;
    int n_err = 0;
    int n_hwe = 0;
    int n_gwe = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    logic [31:0] last_gpr = 32'd0;

    muldiv_ctrl #(.MUL_CYCLES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_srca(srca), .i_srcb(srcb), .i_hi(hi_i), .i_lo(lo_i),
        .i_flush(flush), .i_pipe_stall(pipe_stall),
        .o_stall(stall), .o_busy(busy), .o_done(done),
        .o_hi(hi_o), .o_lo(lo_o), .o_hilo_we(hilo_we),
        .o_gpr_result(gpr_result), .o_gpr_we(gpr_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hilo_we) n_hwe++;
        if (gpr_we)  n_gwe++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic [31:0] eg, output logic isg);
        logic signed [63:0] sa, sb, q, rm;
        logic [63:0] ps, pu, acc, r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ps  = sa * sb;
        pu  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        isg = 1'b0;
        eg  = 32'd0;
        r   = 64'd0;
        case (mop)
            4'd0: r = ps;
            4'd1: r = pu;
            4'd4: r = acc + ps;
            4'd5: r = acc + pu;
            4'd6: r = acc - ps;
            4'd7: r = acc - pu;
            4'd8: begin isg = 1'b1; eg = ps[31:0]; end
            4'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            4'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        ehi = r[63:32];
        elo = r[31:0];
    endfunction

    // Presents one op at a non-edge instant, waits for DONE, optionally holds pipe_stall, checks release.
    task automatic run_op(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input int ps_cyc);
        logic [31:0] ehi, elo, eg;
        logic isg;
        int n, lat, hwe0, gwe0;
        model(mop, a, b, h, l, ehi, elo, eg, isg);
        lat  = (mop == 4'd2 || mop == 4'd3) ? 34 : 4;
        hwe0 = n_hwe;
        gwe0 = n_gwe;
        start = 1'b1; op = mop; srca = a; srcb = b; hi_i = h; lo_i = l;
        #1;
        chk("stall_on_accept", stall, 1);
        n = 0;
        do begin
            @(posedge clk); n++; #1;
        end while (!done && n < 100);
        chk("latency", n, lat);
        start = 1'b0;
        for (int i = 0; i < ps_cyc; i++) begin
            pipe_stall = 1'b1;
            #1;
            chk("held_stall", stall, 1);
            chk("held_no_we", {hilo_we, gpr_we}, 0);
            chk("held_done", done, 1);
            @(posedge clk); #1;
        end
        pipe_stall = 1'b0;
        #1;
        chk("done", done, 1);
        chk("release_stall", stall, 0);
        if (isg) begin
            chk("gpr_we", gpr_we, 1);
            chk("gpr_hilo_we", hilo_we, 0);
            chk("gpr_result", gpr_result, eg);
            chk("gpr_hi_hold", hi_o, last_hi);
            chk("gpr_lo_hold", lo_o, last_lo);
        end else begin
            chk("hilo_we", hilo_we, 1);
            chk("hilo_gpr_we", gpr_we, 0);
            chk("hi", hi_o, ehi);
            chk("lo", lo_o, elo);
        end
        @(posedge clk); #1;
        chk("idle_after", busy, 0);
        chk("hilo_pulses", n_hwe - hwe0, isg ? 0 : 1);
        chk("gpr_pulses", n_gwe - gwe0, isg ? 1 : 0);
        if (isg) last_gpr = eg;
        else begin last_hi = ehi; last_lo = elo; end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int n, hwe0;

        #2;
        chk("rst_outs", {stall, busy, done, hilo_we, gpr_we}, 0);
        chk("rst_data", {hi_o, lo_o}, 0);
        chk("rst_gpr", gpr_result, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(4'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        run_op(4'd3, 32'd100, 32'd7, 0, 0, 0);
        run_op(4'd2, 32'h1234_5678, 32'd0, 0, 0, 0);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(4'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(4'd7, 32'd1, 32'd1, 32'd0, 32'd0, 0);
        run_op(4'd8, 32'd3, 32'hFFFF_FFFC, 0, 0, 0);
        run_op(4'd0, 32'h0001_0003, 32'h0000_0005, 0, 0, 3);

        // Invalid op and flush-with-start are both ignored in IDLE.
        start = 1'b1; op = 4'd12; #1;
        chk("invalid_no_stall", stall, 0);
        @(posedge clk); #1;
        chk("invalid_idle", busy, 0);
        op = 4'd0; flush = 1'b1; #1;
        chk("flush_start_no_stall", stall, 0);
        @(posedge clk); #1;
        chk("flush_start_idle", busy, 0);
        flush = 1'b0; start = 1'b0;

        // Flush at cycle 10 of a DIV, then MULT next cycle.
        hwe0 = n_hwe;
        start = 1'b1; op = 4'd2; srca = 32'd1000; srcb = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b1; #1;
        chk("flush_div_busy", busy, 1);
        @(posedge clk); #1;
        flush = 1'b0; #1;
        chk("flush_idle", busy, 0);
        chk("flush_stall_drop", stall, 0);
        run_op(4'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0);
        chk("flush_no_extra_we", n_hwe - hwe0, 1);

        // Reset mid-DIV clears everything and produces no write.
        hwe0 = n_hwe;
        start = 1'b1; op = 4'd3; srca = 32'd99; srcb = 32'd4;
        repeat (15) @(posedge clk);
        #1;
        start = 1'b0; rst = 1'b1; #2;
        chk("rstmid_flags", {stall, busy, done, hilo_we, gpr_we}, 0);
        chk("rstmid_data", {hi_o, lo_o}, 0);
        chk("rstmid_gpr", gpr_result, 0);
        @(negedge clk); rst = 1'b0;
        last_hi = 32'd0; last_lo = 32'd0;
        n = 0;
        repeat (40) begin @(posedge clk); #1; if (busy) n++; end
        chk("rstmid_stays_idle", n, 0);
        chk("rstmid_no_we", n_hwe - hwe0, 0);

        for (int k = 0; k < 30; k++) begin
            rop = 4'($urandom_range(0, 8));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, $urandom, $urandom, (k % 5 == 0) ? 2 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
